// File: rtl/NVP_v1_constants.sv
// Shared accelerator constants and the output-writer FSM encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package NVP_v1_constants;

  localparam int ACTIVATION_BANK_BIT_WIDTH   = 64;
  localparam int ACTIVATION_DATA_WIDTH       = 8;
  localparam int NUMBER_OF_PE_ARRAYS_PER_ROW = 4;

  // Elements held by one activation-bank word, and input beats needed to fill it.
  localparam int PACK           = ACTIVATION_BANK_BIT_WIDTH / ACTIVATION_DATA_WIDTH;
  localparam int BEATS_PER_WORD = PACK / NUMBER_OF_PE_ARRAYS_PER_ROW;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RUN  = 2'd1,
    WR_DONE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/output_word_packer.sv
// Collects PE-array beats into one bank-wide word; a short line end flushes a zero-filled word.
// Latency: word and strobe are registered, one cycle after the completing beat is accepted.
// Backpressure: none; accepts one beat per cycle, including the cycle a word is emitted.
module output_word_packer #(
  parameter int BEAT_WIDTH = NVP_v1_constants::NUMBER_OF_PE_ARRAYS_PER_ROW *
                             NVP_v1_constants::ACTIVATION_DATA_WIDTH,
  parameter int BEATS      = NVP_v1_constants::BEATS_PER_WORD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        beat_accept,
  input  logic                        line_end,
  input  logic [BEAT_WIDTH-1:0]       beat_data,
  output logic                        emit,
  output logic [BEAT_WIDTH*BEATS-1:0] word,
  output logic                        word_valid
);

  localparam int WORD_WIDTH = BEAT_WIDTH * BEATS;
  localparam int LANE_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS - 1);

  logic [LANE_W-1:0]     lane;
  logic [WORD_WIDTH-1:0] pack_reg;
  logic [WORD_WIDTH-1:0] merged;

  // Current word with the incoming beat dropped into its lane group
  always_comb begin
    merged = pack_reg;
    for (int b = 0; b < BEATS; b++) begin
      if (lane == LANE_W'(b)) begin
        merged[b*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
      end
    end
    emit = beat_accept & (line_end | (lane == LAST_LANE));
  end

  // Lane bookkeeping; the pack register is zeroed after each emit so short words zero-fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane       <= '0;
      pack_reg   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= emit;
      if (emit) begin
        word <= merged;
      end
      if (clear) begin
        lane     <= '0;
        pack_reg <= '0;
      end else if (beat_accept) begin
        if (emit) begin
          lane     <= '0;
          pack_reg <= '0;
        end else begin
          lane     <= lane + LANE_W'(1);
          pack_reg <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/output_array_writer.sv
// Packs PE-array results into bank words and drives the activation-buffer write port.
// Latency: one cycle from the completing beat to the write strobe; done pulses one cycle after the last strobe.
// Backpressure: none downstream; ready is high for the whole RUN state, one beat per cycle.
module output_array_writer
  import NVP_v1_constants::*;
#(
  parameter int ACTIVATION_BANK_BIT_WIDTH       = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH,
  parameter int ACTIVATION_DATA_WIDTH           = NVP_v1_constants::ACTIVATION_DATA_WIDTH,
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW     = NVP_v1_constants::NUMBER_OF_PE_ARRAYS_PER_ROW,
  parameter int OUTPUT_WRITER_ADDRESS_BIT_WIDTH = 16,
  parameter int REGISTER_WIDTH                  = 32
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   i_start,
  input  logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0]             i_cfg_base_address,
  input  logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0]             i_cfg_line_stride,
  input  logic [REGISTER_WIDTH-1:0]                              i_cfg_line_elements,
  input  logic [REGISTER_WIDTH-1:0]                              i_cfg_line_count,
  input  logic [NUMBER_OF_PE_ARRAYS_PER_ROW*ACTIVATION_DATA_WIDTH-1:0] i_pe_data,
  input  logic                                                   i_pe_valid,
  output logic                                                   o_pe_ready,
  output logic [ACTIVATION_BANK_BIT_WIDTH-1:0]                   o_output_array,
  output logic [OUTPUT_WRITER_ADDRESS_BIT_WIDTH-1:0]             o_output_address,
  output logic                                                   o_output_valid,
  output logic                                                   o_busy,
  output logic                                                   o_done
);

  localparam int AW             = OUTPUT_WRITER_ADDRESS_BIT_WIDTH;
  localparam int RW             = REGISTER_WIDTH;
  localparam int LANES_PER_WORD = ACTIVATION_BANK_BIT_WIDTH / ACTIVATION_DATA_WIDTH;
  localparam int BEATS_IN_WORD  = LANES_PER_WORD / NUMBER_OF_PE_ARRAYS_PER_ROW;
  localparam int BEAT_WIDTH     = NUMBER_OF_PE_ARRAYS_PER_ROW * ACTIVATION_DATA_WIDTH;
  localparam logic [RW-1:0] ELEMS_PER_BEAT = RW'(NUMBER_OF_PE_ARRAYS_PER_ROW);

  // The word must split evenly into elements and the elements evenly into beats
  if ((ACTIVATION_BANK_BIT_WIDTH % ACTIVATION_DATA_WIDTH) != 0 ||
      (LANES_PER_WORD % NUMBER_OF_PE_ARRAYS_PER_ROW) != 0) begin : g_bad_geometry
    $error("output_array_writer: bank width must be a whole number of PE beats");
  end

  wr_state_t state;
  wr_state_t next_state;

  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_stride;
  logic [RW-1:0] cfg_elems;
  logic [RW-1:0] cfg_lines;

  logic [RW-1:0] elem_cnt;      // elements already accepted in the current line
  logic [RW-1:0] line_cnt;      // index of the current line
  logic [AW-1:0] line_offset;   // running line*stride, wraps with the address space
  logic [AW-1:0] word_in_line;

  logic accept;
  logic line_end;
  logic layer_end;
  logic start_layer;
  logic cfg_empty;
  logic emit;
  logic done_now;

  assign accept      = i_pe_valid & o_pe_ready;
  assign line_end    = (elem_cnt + ELEMS_PER_BEAT) >= cfg_elems;
  assign layer_end   = line_end & ((line_cnt + RW'(1)) == cfg_lines);
  assign start_layer = (state == WR_IDLE) & i_start;
  assign cfg_empty   = (i_cfg_line_elements == '0) | (i_cfg_line_count == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WR_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: start only from IDLE, leave RUN on the final beat of the final line
  always_comb begin
    next_state = state;
    case (state)
      WR_IDLE: if (i_start) next_state = cfg_empty ? WR_DONE : WR_RUN;
      WR_RUN:  if (accept && layer_end) next_state = WR_DONE;
      WR_DONE: next_state = WR_IDLE;
      default: next_state = WR_IDLE;
    endcase
  end

  // State-decoded handshake and status
  always_comb begin
    o_pe_ready = (state == WR_RUN);
    o_busy     = (state != WR_IDLE);
    done_now   = (state == WR_DONE);
  end

  // Done is registered so it lands the cycle after the last strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_done <= 1'b0;
    end else begin
      o_done <= done_now;
    end
  end

  // Config latch and line/word position tracking; line offset grows by stride per line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_base     <= '0;
      cfg_stride   <= '0;
      cfg_elems    <= '0;
      cfg_lines    <= '0;
      elem_cnt     <= '0;
      line_cnt     <= '0;
      line_offset  <= '0;
      word_in_line <= '0;
    end else if (start_layer) begin
      cfg_base     <= i_cfg_base_address;
      cfg_stride   <= i_cfg_line_stride;
      cfg_elems    <= i_cfg_line_elements;
      cfg_lines    <= i_cfg_line_count;
      elem_cnt     <= '0;
      line_cnt     <= '0;
      line_offset  <= '0;
      word_in_line <= '0;
    end else if (accept) begin
      if (line_end) begin
        elem_cnt     <= '0;
        word_in_line <= '0;
        line_cnt     <= line_cnt + RW'(1);
        line_offset  <= line_offset + cfg_stride;
      end else begin
        elem_cnt <= elem_cnt + ELEMS_PER_BEAT;
        if (emit) begin
          word_in_line <= word_in_line + AW'(1);
        end
      end
    end
  end

  // Write address captured alongside the packed word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_output_address <= '0;
    end else if (emit) begin
      o_output_address <= cfg_base + line_offset + word_in_line;
    end
  end

  output_word_packer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (BEATS_IN_WORD)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_layer),
    .beat_accept (accept),
    .line_end    (line_end),
    .beat_data   (i_pe_data),
    .emit        (emit),
    .word        (o_output_array),
    .word_valid  (o_output_valid)
  );

endmodule

// File: tb/tb_output_array_writer.sv
// Scoreboard bench for output_array_writer: expected words queued at stimulus time, popped on strobes.
// Covers reset state, dense/sparse beats, partial words, address wrap, mid-layer reset, empty layer, ignored restart.
module tb_output_array_writer;

  localparam int N   = 4;
  localparam int BPW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [15:0] i_cfg_base_address;
  logic [15:0] i_cfg_line_stride;
  logic [31:0] i_cfg_line_elements;
  logic [31:0] i_cfg_line_count;
  logic [31:0] i_pe_data;
  logic        i_pe_valid;
  logic        o_pe_ready;
  logic [63:0] o_output_array;
  logic [15:0] o_output_address;
  logic        o_output_valid;
  logic        o_busy;
  logic        o_done;

  output_array_writer dut (
    .clk                 (clk),
    .reset               (reset),
    .i_start             (i_start),
    .i_cfg_base_address  (i_cfg_base_address),
    .i_cfg_line_stride   (i_cfg_line_stride),
    .i_cfg_line_elements (i_cfg_line_elements),
    .i_cfg_line_count    (i_cfg_line_count),
    .i_pe_data           (i_pe_data),
    .i_pe_valid          (i_pe_valid),
    .o_pe_ready          (o_pe_ready),
    .o_output_array      (o_output_array),
    .o_output_address    (o_output_address),
    .o_output_valid      (o_output_valid),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
    int          beat;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc [0:1023];
  int   g = 0;
  int   last_strobe_cyc = -1;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every strobe must match the oldest queued word and land one cycle after its completing beat
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && o_output_valid) begin
      check("strobe_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word_data", o_output_array, e.data);
        check("word_addr", 64'(o_output_address), 64'(e.addr));
        check("strobe_latency", 64'(cyc), 64'(acc_cyc[e.beat] + 1));
      end
      last_strobe_cyc = cyc;
    end
  end

  // Called at a falling edge; beat is presented for exactly one rising edge
  task automatic send_beat(input logic [31:0] d);
    i_pe_valid = 1'b1;
    i_pe_data  = d;
    check("pe_ready", 64'(o_pe_ready), 64'd1);
    acc_cyc[g] = cyc;
    g++;
    @(negedge clk);
    i_pe_valid = 1'b0;
  endtask

  task automatic run_layer(input logic [15:0] base, input logic [15:0] stride,
                           input int elems, input int lines,
                           input bit gap, input bit inj, input logic [7:0] first);
    int          nb;
    int          nw;
    int          g0;
    int          s;
    int          lastb;
    bit          seen;
    logic [63:0] word;
    logic [31:0] d;
    exp_t        e;
    nb = elems / N;
    nw = (nb + BPW - 1) / BPW;
    g0 = g;
    // Reference words: element i of line l has value first + l*elems + i
    for (int l = 0; l < lines; l++) begin
      for (int w = 0; w < nw; w++) begin
        word  = '0;
        lastb = ((w + 1) * BPW < nb) ? (w + 1) * BPW - 1 : nb - 1;
        for (int b = w * BPW; b <= lastb; b++) begin
          for (int k = 0; k < N; k++) begin
            word[((b - w * BPW) * N + k) * 8 +: 8] = 8'(int'(first) + l * elems + b * N + k);
          end
        end
        e.data = word;
        e.addr = 16'(int'(base) + l * int'(stride) + w);
        e.beat = g0 + l * nb + lastb;
        sb.push_back(e);
      end
    end
    i_cfg_base_address  = base;
    i_cfg_line_stride   = stride;
    i_cfg_line_elements = 32'(elems);
    i_cfg_line_count    = 32'(lines);
    i_start = 1'b1;
    s = cyc;
    @(negedge clk);
    i_start = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < N; k++) d[k*8 +: 8] = 8'(int'(first) + l * elems + b * N + k);
        if (inj && l == 0 && b == 1) begin
          i_start             = 1'b1;
          i_cfg_base_address  = 16'h5555;
          i_cfg_line_stride   = 16'h0033;
          i_cfg_line_elements = 32'd4;
          i_cfg_line_count    = 32'd7;
        end
        send_beat(d);
        i_start = 1'b0;
        if (gap) @(negedge clk);
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (o_done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      if (lines == 0 || elems == 0) check("done_timing", 64'(cyc), 64'(s + 2));
      else check("done_timing", 64'(cyc), 64'(last_strobe_cyc + 1));
    end
    check("busy_after_done", 64'(o_busy), 64'd0);
    check("ready_after_done", 64'(o_pe_ready), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    check("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    reset               = 1'b1;
    i_start             = 1'b0;
    i_cfg_base_address  = '0;
    i_cfg_line_stride   = '0;
    i_cfg_line_elements = '0;
    i_cfg_line_count    = '0;
    i_pe_data           = '0;
    i_pe_valid          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(o_output_valid), 64'd0);
    check("rst_array", o_output_array, 64'd0);
    check("rst_addr", 64'(o_output_address), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ready", 64'(o_pe_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    // Beats offered in IDLE must not be taken
    i_pe_valid = 1'b1;
    i_pe_data  = 32'hDEADBEEF;
    check("idle_ready", 64'(o_pe_ready), 64'd0);
    @(negedge clk);
    i_pe_valid = 1'b0;
    check("idle_no_strobe", 64'(o_output_valid), 64'd0);

    // Dense: two lines of two words each
    run_layer(16'h0100, 16'd4, 16, 2, 1'b0, 1'b0, 8'h10);
    // Partial trailing word, zero-filled
    run_layer(16'h0040, 16'd8, 12, 1, 1'b0, 1'b0, 8'h01);
    // Valid toggling every cycle
    run_layer(16'h0100, 16'd4, 16, 2, 1'b1, 1'b0, 8'h80);
    // Address wrap
    run_layer(16'hFFFE, 16'd1, 8, 3, 1'b0, 1'b0, 8'h30);

    // Reset after the first beat of a word: no strobe, then a clean restart
    i_cfg_base_address  = 16'h0200;
    i_cfg_line_stride   = 16'd1;
    i_cfg_line_elements = 32'd8;
    i_cfg_line_count    = 32'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    send_beat(32'hAABBCCDD);
    check("midrst_no_strobe", 64'(o_output_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_valid", 64'(o_output_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_layer(16'h0200, 16'd1, 8, 1, 1'b0, 1'b0, 8'h50);

    // Empty layers
    run_layer(16'h0010, 16'd1, 8, 0, 1'b0, 1'b0, 8'h00);
    run_layer(16'h0010, 16'd1, 0, 3, 1'b0, 1'b0, 8'h00);

    // Restart attempt with new config mid-layer is ignored
    run_layer(16'h0300, 16'd2, 16, 2, 1'b0, 1'b1, 8'hC0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
